// File: rtl/simd_sequencer_if.sv
// simd_sequencer_if: lane-op issue channel and write-back return between sequencer and SIMD ALU
interface simd_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [7:0] op_dst;
  logic [7:0] op_srca;
  logic [7:0] op_srcb;
  logic       wb_valid;
  modport master (output op_valid, op_code, op_dst, op_srca, op_srcb, input op_ready, wb_valid);
  modport slave (input op_valid, op_code, op_dst, op_srca, op_srcb, output op_ready, wb_valid);
endinterface

// File: rtl/simd_sequencer.sv
// simd_sequencer: expands one vector instruction into per-element lane ops and counts ALU write-backs
module simd_sequencer #(
  parameter int         LEN_W           = 8,
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [3:0] BAD_OPCODE      = 4'hF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ins_valid,
  input  logic [31:0]      instr,
  input  logic [LEN_W-1:0] instr_len,
  output logic             ins_done,
  output logic             busy,
  output logic             err,
  simd_sequencer_if.master alu
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t           state;
  logic             ins_valid_q;
  logic [3:0]       code;
  logic [7:0]       dst_base, srca_base, srcb_base;
  logic [LEN_W-1:0] len, idx, completed, completed_nx;
  logic [OW-1:0]    outstanding;
  logic             start, fire, wb_ok, wb_bad, bad_op, unused_rsvd;
  assign unused_rsvd  = ^instr[3:0];
  assign start        = state == IDLE && ins_valid && !ins_valid_q;
  assign bad_op       = instr[31:28] == BAD_OPCODE;
  assign fire         = alu.op_valid && alu.op_ready;
  // a write-back with nothing in flight is spurious: flagged, never counted
  assign wb_ok        = alu.wb_valid && outstanding != '0;
  assign wb_bad       = alu.wb_valid && outstanding == '0;
  assign completed_nx = completed + LEN_W'(wb_ok);
  assign busy         = state != IDLE;
  assign ins_done     = state == DONE;
  assign alu.op_valid = state == ISSUE && outstanding < OW'(MAX_OUTSTANDING);
  assign alu.op_code  = code;
  assign alu.op_dst   = dst_base + 8'(idx);
  assign alu.op_srca  = srca_base + 8'(idx);
  assign alu.op_srcb  = srcb_base + 8'(idx);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      ins_valid_q <= 1'b0;
      err         <= 1'b0;
      code        <= '0;
      dst_base    <= '0;
      srca_base   <= '0;
      srcb_base   <= '0;
      len         <= '0;
      idx         <= '0;
      completed   <= '0;
      outstanding <= '0;
    end else begin
      ins_valid_q <= ins_valid;
      outstanding <= outstanding + OW'(fire) - OW'(wb_ok);
      if (wb_bad) err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          {code, dst_base, srca_base, srcb_base} <= instr[31:4];
          len       <= instr_len;
          idx       <= '0;
          completed <= '0;
          err       <= bad_op || wb_bad;
          state     <= (instr_len == '0 || bad_op) ? DONE : ISSUE;
        end
        ISSUE: begin
          completed <= completed_nx;
          if (fire) begin
            idx <= idx + LEN_W'(1);
            if (idx == len - LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          completed <= completed_nx;
          if (completed_nx == len) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/simd_sequencer.md
Name: simd_sequencer

Overview:
- Decoder/sequencer stage directly downstream of the PS status manager.
- Consumes the level `ins_valid` and the instruction registers written by the PS.
- Expands one vector instruction into `len` per-element lane operations and issues them to the SIMD ALU over a valid/ready handshake.
- Counts ALU write-back completions and returns a single-cycle `ins_done` pulse to the status manager.

Parameters:
LEN_W, 8, width of instruction element count
MAX_OUTSTANDING, 4, max issued-but-not-written-back ops (power of 2, 1..16)
BAD_OPCODE, 4'hF, opcode value treated as illegal

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
ins_valid  input  1  level from status manager; rising edge starts an instruction
instr  input  32  instruction: [31:28] opcode, [27:20] dst_base, [19:12] srca_base, [11:4] srcb_base, [3:0] reserved
instr_len  input  LEN_W  number of elements to process
ins_done  output  1  one-cycle pulse: instruction complete
busy  output  1  high from start until the ins_done cycle inclusive
err  output  1  sticky error flag, cleared on next accepted start
op_valid  output  1  lane op valid to ALU
op_ready  input  1  ALU accepts op when op_valid && op_ready
op_code  output  4  latched opcode
op_dst  output  8  destination address
op_srca  output  8  source A address
op_srcb  output  8  source B address
wb_valid  input  1  one pulse per completed ALU op

Behaviour:
- Reset (async, rstn=0): state IDLE; ins_done=0, busy=0, err=0, op_valid=0, op_code/op_dst/op_srca/op_srcb=0; counters=0; edge register ins_valid_q=0. Reset mid-instruction aborts it silently; no ins_done is produced.
- Start: `ins_valid && !ins_valid_q` while in IDLE.
  - Latch instr fields and instr_len; clear err; issue index idx=0; completed=0.
  - Edges seen outside IDLE are ignored, not queued.
  - A held-high ins_valid never restarts.
- States:
  - IDLE -> ISSUE on start with len!=0 and opcode!=BAD_OPCODE.
  - IDLE -> DONE on start with len==0 (NOP, no ops issued).
  - IDLE -> DONE on start with opcode==BAD_OPCODE; err set; no ops issued.
  - ISSUE: op_valid=1 only when outstanding<MAX_OUTSTANDING.
    - op_dst=dst_base+idx, op_srca=srca_base+idx, op_srcb=srcb_base+idx, each mod 256 (8-bit wrap, no carry).
    - On handshake, idx increments.
    - After the handshake with idx==len-1 -> DRAIN.
  - DRAIN: op_valid=0; -> DONE when completed==len, including a wb_valid arriving this cycle.
  - DONE: ins_done=1 for exactly one cycle, busy=1; -> IDLE next cycle.
- Latency: start edge sampled at cycle N -> busy=1 and op_valid=1 at N+1. NOP or illegal opcode -> ins_done at N+1.
- Outstanding count = issued − completed.
  - Simultaneous handshake and wb_valid leaves it unchanged.
  - At MAX_OUTSTANDING, op_valid drops the same cycle the count is reached.
  - op_valid reasserts the cycle after a wb_valid frees a slot.
- Op outputs hold stable while op_valid && !op_ready; ALU may stall indefinitely.
- wb_valid with outstanding==0 (including in IDLE or DONE): ignored for counting, sets err. This does not change state.
- The ins_done cycle's err value is final for that instruction. err stays set through IDLE until the next start.
- busy=0 only in IDLE.

Test Plan:
- Basic: instr={4'h2,8'h10,8'h20,8'h30,4'h0}, len=3, op_ready=1, ALU returns wb_valid 2 cycles after each op -> ops (dst,a,b)=(10,20,30),(11,21,31),(12,22,32); one ins_done pulse after the third wb_valid; err=0; busy deasserts the cycle after.
- Backpressure/outstanding: len=8, MAX_OUTSTANDING=4, wb_valid withheld -> exactly 4 handshakes, then op_valid=0. Release one wb_valid -> next op issues the following cycle. Total 8 ops, ins_done after wb #8. Also hold op_ready=0 for 5 cycles mid-stream -> op fields stable.
- Wrap/edge cases: dst_base=8'hFE, len=4 -> op_dst FE,FF,00,01. len=0 -> ins_done one cycle after start, no op_valid.
- Illegal/spurious: opcode=4'hF, len=5 -> no ops; ins_done at N+1; err=1 held until next start. Then wb_valid pulse in IDLE -> err=1, state stays IDLE.
- Start semantics: hold ins_valid high 50 cycles across an instruction -> exactly one ins_done. Toggle ins_valid low/high while busy -> ignored. Edge after return to IDLE -> new instruction runs.
- Reset: assert rstn=0 in ISSUE with 2 ops outstanding -> all outputs 0 immediately; no ins_done. After release, a fresh start runs normally from idx=0.
